rx_fifo_ext: RTL and testbench

Parametrised receive FIFO, the next generation of the fixed 8x8 receive buffer. It sits between the serial receiver's byte-assembly logic and the downstream consumer. Width and depth are configurable. On top of the baseline it adds:
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- a synchronous flush;
- sticky overrun and underrun error flags with an explicit clear.

---
 rtl/rx_fifo_ext.sv | 133 +++++++++++++
 tb/tb_rx_fifo_ext.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_ext.sv
// Parametrised first-word-fall-through receive FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, flush and sticky errors.
module rx_fifo_ext #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // Handshake: w_enable / r_enable are single-cycle requests sampled at the
    // rising edge; a request is accepted on that same edge when push_ok / pop_ok
    // is true, otherwise it is dropped and recorded in the sticky error flags.
    // There is no stall: full/empty are the only back-pressure indications.

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_BITS-1:0]  wptr_q;
    logic [ADDR_BITS-1:0]  rptr_q;
    logic [CW-1:0]         count_q;
    logic                  overrun_q;
    logic                  underrun_q;

    logic                  full_c;
    logic                  empty_c;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovr_event;
    logic                  udr_event;

    // Status decodes come only from the registered count.
    always_comb begin
        full_c  = (count_q == DEPTH_C);
        empty_c = (count_q == '0);
    end

    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
    always_comb begin
        push_ok   = w_enable & (~full_c | r_enable);
        pop_ok    = r_enable & ~empty_c;
        ovr_event = w_enable & full_c & ~r_enable;
        udr_event = r_enable & empty_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + ONE_C;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - ONE_C;
            end
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem[wptr_q] <= w_data;
        end
    end

    // An error event on the same edge as clr_err wins; flush raises no events.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else if (flush) begin
            if (clr_err) begin
                overrun_q  <= 1'b0;
                underrun_q <= 1'b0;
            end
        end else begin
            if (ovr_event) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
            if (udr_event) begin
                underrun_q <= 1'b1;
            end else if (clr_err) begin
                underrun_q <= 1'b0;
            end
        end
    end

    always_comb begin
        r_data       = empty_c ? '0 : mem[rptr_q];
        empty        = empty_c;
        full         = full_c;
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        count        = count_q;
        overrun      = overrun_q;
        underrun     = underrun_q;
    end

endmodule

// File: tb/tb_rx_fifo_ext.sv
// Bench for rx_fifo_ext: default instance (8x8) and a 16x16 instance, checked
// every cycle against a queue-based reference model.
module tb_rx_fifo_ext;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // instance A: defaults
    logic       a_rst, a_flush, a_clr, a_w, a_r;
    logic [7:0] a_wd, a_rdata;
    logic       a_empty, a_full, a_af, a_ae, a_ovr, a_udr;
    logic [3:0] a_count;

    // instance B: 16 wide, 16 deep, AF 15, AE 0
    logic        b_rst, b_flush, b_clr, b_w, b_r;
    logic [15:0] b_wd, b_rdata;
    logic        b_empty, b_full, b_af, b_ae, b_ovr, b_udr;
    logic [4:0]  b_count;

    rx_fifo_ext u_a (
        .clk(tb_clk), .rst(a_rst), .flush(a_flush), .clr_err(a_clr),
        .w_enable(a_w), .w_data(a_wd), .r_enable(a_r), .r_data(a_rdata),
        .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overrun(a_ovr), .underrun(a_udr)
    );

    rx_fifo_ext #(.DATA_WIDTH(16), .ADDR_BITS(4), .AF_LEVEL(15), .AE_LEVEL(0)) u_b (
        .clk(tb_clk), .rst(b_rst), .flush(b_flush), .clr_err(b_clr),
        .w_enable(b_w), .w_data(b_wd), .r_enable(b_r), .r_data(b_rdata),
        .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overrun(b_ovr), .underrun(b_udr)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        m_ovr[2];
    logic        m_udr[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a FIFO is an ordered list bounded by its depth.
    task automatic model(input int inst, input bit rst_v, input bit fl, input bit clr,
                         input bit w, input logic [15:0] wd, input bit r);
        logic [15:0] q[$];
        int          depth;
        bit          was_full, was_empty, ev_o, ev_u;
        q     = (inst == 0) ? qa : qb;
        depth = (inst == 0) ? 8 : 16;
        if (rst_v) begin
            q.delete();
            m_ovr[inst] = 1'b0;
            m_udr[inst] = 1'b0;
        end else if (fl) begin
            q.delete();
            if (clr) begin
                m_ovr[inst] = 1'b0;
                m_udr[inst] = 1'b0;
            end
        end else begin
            was_full  = (q.size() == depth);
            was_empty = (q.size() == 0);
            ev_o = w && was_full && !r;
            ev_u = r && was_empty;
            if (r && !was_empty) void'(q.pop_front());
            if (w && (!was_full || r)) q.push_back((inst == 0) ? (wd & 16'h00ff) : wd);
            m_ovr[inst] = ev_o ? 1'b1 : (clr ? 1'b0 : m_ovr[inst]);
            m_udr[inst] = ev_u ? 1'b1 : (clr ? 1'b0 : m_udr[inst]);
        end
        if (inst == 0) qa = q; else qb = q;
    endtask

    task automatic check_all(input int inst);
        logic [15:0] q[$];
        int          af, ae, depth, n;
        string       p;
        q     = (inst == 0) ? qa : qb;
        n     = q.size();
        depth = (inst == 0) ? 8 : 16;
        af    = (inst == 0) ? 6 : 15;
        ae    = (inst == 0) ? 2 : 0;
        p     = (inst == 0) ? "a" : "b";
        if (inst == 0) begin
            chk({p, "_rdata"}, a_rdata, (n > 0) ? q[0] : 0);
            chk({p, "_count"}, a_count, n);
            chk({p, "_empty"}, a_empty, n == 0);
            chk({p, "_full"},  a_full,  n == depth);
            chk({p, "_af"},    a_af,    n >= af);
            chk({p, "_ae"},    a_ae,    n <= ae);
            chk({p, "_ovr"},   a_ovr,   m_ovr[0]);
            chk({p, "_udr"},   a_udr,   m_udr[0]);
        end else begin
            chk({p, "_rdata"}, b_rdata, (n > 0) ? q[0] : 0);
            chk({p, "_count"}, b_count, n);
            chk({p, "_empty"}, b_empty, n == 0);
            chk({p, "_full"},  b_full,  n == depth);
            chk({p, "_af"},    b_af,    n >= af);
            chk({p, "_ae"},    b_ae,    n <= ae);
            chk({p, "_ovr"},   b_ovr,   m_ovr[1]);
            chk({p, "_udr"},   b_udr,   m_udr[1]);
        end
    endtask

    // Drive one instance for one edge (the other idles), then check it.
    task automatic step(input int inst, input bit rst_v, input bit fl, input bit clr,
                        input bit w, input logic [15:0] wd, input bit r);
        a_rst = 0; a_flush = 0; a_clr = 0; a_w = 0; a_wd = '0; a_r = 0;
        b_rst = 0; b_flush = 0; b_clr = 0; b_w = 0; b_wd = '0; b_r = 0;
        if (inst == 0) begin
            a_rst = rst_v; a_flush = fl; a_clr = clr; a_w = w; a_wd = wd[7:0]; a_r = r;
        end else begin
            b_rst = rst_v; b_flush = fl; b_clr = clr; b_w = w; b_wd = wd; b_r = r;
        end
        @(posedge tb_clk);
        model(inst, rst_v, fl, clr, w, wd, r);
        #1;
        check_all(inst);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl, clr, w, r;
        int wp;
        a_rst = 1; a_flush = 0; a_clr = 0; a_w = 0; a_wd = '0; a_r = 0;
        b_rst = 1; b_flush = 0; b_clr = 0; b_w = 0; b_wd = '0; b_r = 0;
        m_ovr[0] = 0; m_udr[0] = 0; m_ovr[1] = 0; m_udr[1] = 0;
        #1;

        // reset values on both instances
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("a_reset_empty", a_empty, 1);
        chk("a_reset_rdata", a_rdata, 0);

        // fill with 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 1, 16'(i), 0);
            if (i == 3) chk("a_ae_falls_3", a_ae, 0);
            if (i == 6) chk("a_af_rises_6", a_af, 1);
        end
        chk("a_full_8", a_full, 1);
        chk("a_count_8", a_count, 8);

        // overrun on full, then clear
        step(0, 0, 0, 0, 1, 16'hAA, 0);
        chk("a_overrun_set", a_ovr, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("a_overrun_clr", a_ovr, 0);

        // drain in order
        for (int i = 1; i <= 8; i++) begin
            chk("a_pop_order", a_rdata, i);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("a_empty_after_drain", a_empty, 1);

        // pop + push on empty
        step(0, 0, 0, 0, 1, 16'h5C, 1);
        chk("a_udr_push_pop_empty", a_udr, 1);
        chk("a_rdata_5c", a_rdata, 8'h5C);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);

        // full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 16'(8'h10 + i), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 16'(8'h18 + i), 1);
        chk("a_full_stream_count", a_count, 8);
        chk("a_full_stream_ovr", a_ovr, 0);

        // flush, underrun, partial fill, flush with push pending
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 16'(8'h40 + i), 0);
        step(0, 0, 1, 0, 1, 16'h77, 1);
        chk("a_flush_count", a_count, 0);
        chk("a_flush_keeps_udr", a_udr, 1);

        // reset mid-burst with push asserted
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'(8'h60 + i), 0);
        step(0, 1, 0, 0, 1, 16'h99, 0);
        chk("a_rst_udr", a_udr, 0);
        chk("a_rst_ovr", a_ovr, 0);

        // wide/deep instance boundaries
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 1, 16'(16'hA000 + i), 0);
            if (i == 0) chk("b_ae_off_at_1", b_ae, 0);
            if (i == 13) chk("b_af_low_at_14", b_af, 0);
            if (i == 14) chk("b_af_at_15", b_af, 1);
        end
        chk("b_full_16", b_full, 1);
        step(1, 0, 0, 0, 1, 16'hFFFF, 0);
        chk("b_overrun", b_ovr, 1);

        // random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 1000; i++) begin
            wp  = ((i / 100) % 2 == 1) ? 75 : 35;
            w   = ($urandom_range(0, 99) < wp);
            r   = ($urandom_range(0, 99) < 55);
            fl  = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 19) == 0);
            step(1, 0, fl, clr, w, 16'($urandom), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
